// File: rtl/regfile_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regfile_ctrl_pkg
// Shared definitions for the register-file write-port controller:
//   - controller state enum (INIT sweep / RUN arbitration)
//   - default address width, data width and register count
//   - first and last addresses cleared by the post-reset sweep
// -----------------------------------------------------------------------------
package regfile_ctrl_pkg;

    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_NREGS   = 32;

    // Register 0 is hardwired to zero, so the sweep starts at 1.
    localparam int SWEEP_FIRST = 1;
    localparam int SWEEP_LAST  = 31;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
// Pending-write mask for long-latency results. A set marks a register as
// awaiting a write; a clear releases it when that write commits.
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   set_en_i / set_addr_i    mark register pending (address 0 ignored)
//   clr_en_i / clr_addr_i    release register (write committing this edge)
//   busy_o                   registered pending mask, bit 0 always 0
// -----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    output logic [NREGS-1:0]  busy_o
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next mask: a set beats a same-address clear so a freshly issued op is never lost.
    always_comb begin
        busy_d = busy_q;
        for (int i = 1; i < NREGS; i++) begin
            if (set_en_i && (set_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (clr_en_i && (clr_addr_i == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
        busy_d[0] = 1'b0;
    end

    // Mask register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= {NREGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/regfile_write_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_write_ctrl
// Owns the single write port of the 32x32 register file. After reset it clears
// registers 1..31 (the file itself has no reset so it can map to RAM), then
// arbitrates round-robin between the pipeline writeback (A) and the
// long-latency unit (B), and tracks pending long-latency destinations.
// Ports:
//   clock, Reset_n                    clock, asynchronous active-low reset
//   a_valid/a_addr/a_data, a_ready    pipeline writeback request
//   b_valid/b_addr/b_data, b_ready    long-latency writeback request
//   sb_set, sb_set_addr               issue of a long-latency op
//   busy                              pending-write mask
//   init_done                         clear sweep complete
//   rf_RegWrite/WriteAddr/WriteData   registered register-file write port
// -----------------------------------------------------------------------------
module regfile_write_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int NREGS  = DEF_NREGS
) (
    input  logic              clock,
    input  logic              Reset_n,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_set_addr,
    output logic [NREGS-1:0]  busy,
    output logic              init_done,
    output logic              rf_RegWrite,
    output logic [ADDR_W-1:0] rf_WriteAddr,
    output logic [DATA_W-1:0] rf_WriteData
);

    localparam logic [ADDR_W-1:0] ADDR_FIRST = ADDR_W'(SWEEP_FIRST);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(SWEEP_LAST);
    localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(32'd1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              prio_q, prio_d;
    logic              init_done_q;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_data_q, rf_data_d;
    logic              from_b_q, from_b_d;

    logic              a_grant_s;
    logic              b_grant_s;
    logic              contend_s;
    logic              sb_set_en_s;
    logic              sb_clr_en_s;

    // Readies are offered only after the sweep; under contention prio_q picks the winner.
    always_comb begin
        a_ready = init_done_q & (~b_valid | prio_q);
        b_ready = init_done_q & (~a_valid | ~prio_q);
    end

    assign a_grant_s = a_valid & a_ready;
    assign b_grant_s = b_valid & b_ready;
    assign contend_s = init_done_q & a_valid & b_valid;

    // Next state, sweep counter, priority and the registered write port.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        from_b_d  = 1'b0;
        case (state_q)
            INIT: begin
                rf_we_d   = 1'b1;
                rf_addr_d = cnt_q;
                rf_data_d = DATA_ZERO;
                cnt_d     = cnt_q + ADDR_ONE;
                if (cnt_q == ADDR_LAST) begin
                    state_d = RUN;
                end else begin
                    state_d = INIT;
                end
            end
            RUN: begin
                // Address 0 is accepted but never written into the file.
                if (a_grant_s) begin
                    rf_we_d   = (a_addr != ADDR_ZERO);
                    rf_addr_d = a_addr;
                    rf_data_d = a_data;
                end else if (b_grant_s) begin
                    rf_we_d   = (b_addr != ADDR_ZERO);
                    rf_addr_d = b_addr;
                    rf_data_d = b_data;
                    from_b_d  = 1'b1;
                end else begin
                    rf_we_d   = 1'b0;
                end
                if (contend_s) begin
                    prio_d = ~prio_q;
                end else begin
                    prio_d = prio_q;
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight write.
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= INIT;
            cnt_q       <= ADDR_FIRST;
            prio_q      <= 1'b1;
            init_done_q <= 1'b0;
            rf_we_q     <= 1'b0;
            rf_addr_q   <= ADDR_ZERO;
            rf_data_q   <= DATA_ZERO;
            from_b_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            // One cycle behind RUN so the last sweep write finishes before traffic.
            init_done_q <= (state_q == RUN);
            rf_we_q     <= rf_we_d;
            rf_addr_q   <= rf_addr_d;
            rf_data_q   <= rf_data_d;
            from_b_q    <= from_b_d;
        end
    end

    // B clears its busy bit at the edge its registered write commits.
    assign sb_set_en_s = sb_set & init_done_q;
    assign sb_clr_en_s = rf_we_q & from_b_q;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_scoreboard (
        .clk_i      (clock),
        .rst_ni     (Reset_n),
        .set_en_i   (sb_set_en_s),
        .set_addr_i (sb_set_addr),
        .clr_en_i   (sb_clr_en_s),
        .clr_addr_i (rf_addr_q),
        .busy_o     (busy)
    );

    assign init_done    = init_done_q;
    assign rf_RegWrite  = rf_we_q;
    assign rf_WriteAddr = rf_addr_q;
    assign rf_WriteData = rf_data_q;

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_write_ctrl
// Bench for regfile_write_ctrl: cycle-count based reference model, a plain
// array standing in for the register file, directed cases and random traffic.
// -----------------------------------------------------------------------------
module tb_regfile_write_ctrl;

    logic        clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_addr = 5'd0;
    logic [31:0] a_data = 32'd0;
    logic        b_valid = 1'b0;
    logic [4:0]  b_addr = 5'd0;
    logic [31:0] b_data = 32'd0;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_set_addr = 5'd0;
    logic        a_ready, b_ready, init_done, rf_RegWrite;
    logic [31:0] busy;
    logic [4:0]  rf_WriteAddr;
    logic [31:0] rf_WriteData;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    regfile_write_ctrl dut (
        .clock        (clock),
        .Reset_n      (Reset_n),
        .a_valid      (a_valid),
        .a_addr       (a_addr),
        .a_data       (a_data),
        .a_ready      (a_ready),
        .b_valid      (b_valid),
        .b_addr       (b_addr),
        .b_data       (b_data),
        .b_ready      (b_ready),
        .sb_set       (sb_set),
        .sb_set_addr  (sb_set_addr),
        .busy         (busy),
        .init_done    (init_done),
        .rf_RegWrite  (rf_RegWrite),
        .rf_WriteAddr (rf_WriteAddr),
        .rf_WriteData (rf_WriteData)
    );

    // Register file stand-in: no reset, written from the controller's port.
    logic [31:0] tb_mem [32];
    always @(posedge clock) begin
        if (rf_RegWrite) tb_mem[rf_WriteAddr] <= rf_WriteData;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          m_cyc = 0;        // edges since reset release
    bit          m_prio = 1'b1;
    bit          m_init = 1'b0;
    bit [31:0]   m_busy = 32'd0;
    bit          m_we = 1'b0;
    bit [4:0]    m_addr = 5'd0;
    bit [31:0]   m_data = 32'd0;
    bit          m_pend = 1'b0;    // B write registered, busy clears at next edge
    bit [4:0]    m_pend_addr = 5'd0;
    bit [31:0]   m_mem [32];

    always @(posedge clock or negedge Reset_n) begin
        bit ga, gb;
        int k;
        if (!Reset_n) begin
            m_cyc = 0; m_prio = 1'b1; m_init = 1'b0; m_busy = 32'd0;
            m_we = 1'b0; m_addr = 5'd0; m_data = 32'd0; m_pend = 1'b0; m_pend_addr = 5'd0;
        end else begin
            if (m_we) m_mem[m_addr] = m_data;
            ga = m_init && a_valid && (!b_valid || m_prio);
            gb = m_init && b_valid && (!a_valid || !m_prio);
            if (m_pend) m_busy[m_pend_addr] = 1'b0;
            if (m_init && sb_set && sb_set_addr != 5'd0) m_busy[sb_set_addr] = 1'b1;
            m_pend = gb && (b_addr != 5'd0);
            m_pend_addr = b_addr;
            k = m_cyc + 1;
            if (k <= 31) begin
                m_we = 1'b1; m_addr = 5'(k); m_data = 32'd0;
            end else if (ga) begin
                m_we = (a_addr != 5'd0); m_addr = a_addr; m_data = a_data;
            end else if (gb) begin
                m_we = (b_addr != 5'd0); m_addr = b_addr; m_data = b_data;
            end else begin
                m_we = 1'b0;
            end
            if (m_init && a_valid && b_valid) m_prio = !m_prio;
            m_init = (k >= 32);
            m_cyc = k;
        end
    end

    // Every cycle: all outputs against the model.
    always @(negedge clock) begin
        logic ea, eb;
        ea = m_init && (!b_valid || m_prio);
        eb = m_init && (!a_valid || !m_prio);
        check("rf_RegWrite", rf_RegWrite, m_we);
        check("rf_WriteAddr", rf_WriteAddr, m_addr);
        check("rf_WriteData", rf_WriteData, m_data);
        check("init_done", init_done, m_init);
        check("busy", busy, m_busy);
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0; b_valid = 1'b0; sb_set = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        Reset_n = 1'b0;
        tick(); tick();
        Reset_n = 1'b1;
    endtask

    task automatic wait_init();
        for (int w = 0; w < 40 && !init_done; w++) tick();
        check("init_done_reached", init_done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    nw;
        bit    ok_order;
        int    rdy_seen;
        bit    found;
        string seq;

        // ---------- sweep after reset ----------
        do_reset();
        check("reset_rf_we", rf_RegWrite, 1'b0);
        check("reset_busy", busy, 32'd0);
        a_valid = 1'b1; a_addr = 5'd2; b_valid = 1'b1; b_addr = 5'd3;
        sb_set = 1'b1; sb_set_addr = 5'd9;
        nw = 0; ok_order = 1'b1; rdy_seen = 0;
        for (int k = 1; k <= 32; k++) begin
            tick();
            if (rf_RegWrite) begin
                nw++;
                if (int'(rf_WriteAddr) != nw || rf_WriteData != 32'd0) ok_order = 1'b0;
            end
            if (k <= 31 && (a_ready || b_ready)) rdy_seen++;
            if (k == 31) check("init_done_c31", init_done, 1'b0);
            if (k == 32) begin
                check("init_done_c32", init_done, 1'b1);
                check("sweep_no_grant", rf_RegWrite, 1'b0);
                check("sweep_set_ignored", busy, 32'd0);
                idle_inputs();
            end
        end
        check("sweep_count", nw, 31);
        check("sweep_order", ok_order, 1'b1);
        check("sweep_readies", rdy_seen, 0);

        // ---------- A only ----------
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        tick();
        a_valid = 1'b0;
        check("a_only_we", rf_RegWrite, 1'b1);
        check("a_only_addr", rf_WriteAddr, 5'd5);
        check("a_only_data", rf_WriteData, 32'hDEADBEEF);
        tick();
        check("a_only_we_drop", rf_RegWrite, 1'b0);
        check("a_only_mem", tb_mem[5], 32'hDEADBEEF);

        // ---------- contention ----------
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'h33333333;
        b_valid = 1'b1; b_addr = 5'd4; b_data = 32'h44444444;
        seq = "";
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rf_RegWrite && rf_WriteAddr == 5'd3) seq = {seq, "A"};
            else if (rf_RegWrite && rf_WriteAddr == 5'd4) seq = {seq, "B"};
            else seq = {seq, "-"};
        end
        idle_inputs();
        n_tests++;
        if (seq != "ABAB") begin
            n_fail++;
            $display("FAIL arb_order: got %s expected ABAB", seq);
        end

        // ---------- scoreboard ----------
        sb_set = 1'b1; sb_set_addr = 5'd7;
        tick();
        sb_set = 1'b0;
        check("sb_set7", busy, 32'h00000080);
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h12345678;
        tick();
        b_valid = 1'b0;
        check("sb_b_hs_we", rf_RegWrite, 1'b1);
        check("sb_busy_hold", busy[7], 1'b1);
        tick();
        check("sb_busy_clr", busy[7], 1'b0);
        check("sb_mem7", tb_mem[7], 32'h12345678);
        sb_set = 1'b1; sb_set_addr = 5'd7;
        tick();
        sb_set = 1'b0;
        b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h0BADF00D;
        tick();
        b_valid = 1'b0;
        sb_set = 1'b1; sb_set_addr = 5'd7;
        tick();
        sb_set = 1'b0;
        check("sb_set_wins", busy, 32'h00000080);
        check("sb_mem7_b", tb_mem[7], 32'h0BADF00D);

        // ---------- address 0 ----------
        a_valid = 1'b1; a_addr = 5'd0; a_data = 32'hFFFFFFFF;
        sb_set = 1'b1; sb_set_addr = 5'd0;
        #1;
        check("a0_ready", a_ready, 1'b1);
        tick();
        idle_inputs();
        check("a0_no_we", rf_RegWrite, 1'b0);
        check("a0_busy", busy, 32'h00000080);

        // ---------- reset mid-sweep ----------
        do_reset();
        found = 1'b0;
        for (int w = 0; w < 40; w++) begin
            tick();
            if (rf_RegWrite && rf_WriteAddr == 5'd12) begin
                found = 1'b1;
                break;
            end
        end
        check("rst12_found", found, 1'b1);
        Reset_n = 1'b0;
        #1;
        check("rst12_we", rf_RegWrite, 1'b0);
        check("rst12_addr", rf_WriteAddr, 5'd0);
        check("rst12_busy", busy, 32'd0);
        tick();
        Reset_n = 1'b1;
        tick();
        check("rst12_restart_we", rf_RegWrite, 1'b1);
        check("rst12_restart_addr", rf_WriteAddr, 5'd1);
        wait_init();

        // ---------- random traffic with one mid-traffic reset ----------
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                idle_inputs();
                Reset_n = 1'b0;
                #1;
                check("rst_mid_we", rf_RegWrite, 1'b0);
                check("rst_mid_busy", busy, 32'd0);
                check("rst_mid_init", init_done, 1'b0);
                tick();
                Reset_n = 1'b1;
                wait_init();
            end
            a_valid     = ($urandom_range(0, 1) == 1);
            a_addr      = 5'($urandom_range(0, 31));
            a_data      = $urandom;
            b_valid     = ($urandom_range(0, 2) != 0);
            b_addr      = 5'($urandom_range(0, 7));
            b_data      = $urandom;
            sb_set      = ($urandom_range(0, 2) == 0);
            sb_set_addr = 5'($urandom_range(0, 7));
            tick();
        end
        idle_inputs();
        tick(); tick();
        for (int i = 1; i < 32; i++) check("mem_final", tb_mem[i], m_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the 32×32 register file: clears every register through the single write port after reset and arbitrates that port between two writeback sources. It also keeps a pending-write scoreboard for long-latency results. It sits between the pipeline writeback stage, the multi-cycle unit (mult/div/load) and the register file. The register file's own `Reset` is tied inactive, so its storage can map to RAM.

## Interface
Parameters:
- `ADDR_W`, 5, register address width
- `DATA_W`, 32, data width
- `NREGS`, 32, register count (= 2**ADDR_W)

Ports:
- `clock`  in  1  single clock, rising edge
- `Reset_n`  in  1  asynchronous, active-low reset
- `a_valid` / `a_addr` / `a_data`  in  1 / ADDR_W / DATA_W  pipeline writeback request
- `a_ready`  out  1  A accepted when `a_valid & a_ready` at a rising edge
- `b_valid` / `b_addr` / `b_data`  in  1 / ADDR_W / DATA_W  long-latency unit writeback request
- `b_ready`  out  1  B accepted when `b_valid & b_ready` at a rising edge
- `sb_set`  in  1  issue of a long-latency op; marks `sb_set_addr` pending
- `sb_set_addr`  in  ADDR_W  destination register of the issued op
- `busy`  out  NREGS  pending-write mask; bit i = register i awaits a B write
- `init_done`  out  1  high once the clear sweep is complete
- `rf_RegWrite`  out  1  to register file `RegWrite`
- `rf_WriteAddr`  out  ADDR_W  to register file `WriteAddr`
- `rf_WriteData`  out  DATA_W  to register file `WriteData`

## Operation
- Two states, `INIT` and `RUN`. Reset enters `INIT` with sweep counter = 1.
- `INIT`:
  - each cycle drives `rf_RegWrite`=1, `rf_WriteAddr`=counter, `rf_WriteData`=0; counter increments.
  - after address 31 the controller enters `RUN`, so the sweep lasts 31 cycles. Address 0 is never written.
  - `a_ready`=`b_ready`=0. `sb_set` is ignored.
- `RUN`:
  - `a_ready` = `~b_valid | prio_a`; `b_ready` = `~a_valid | ~prio_a`. Neither ready depends on its own valid.
  - `prio_a` resets to 1. It toggles only on a cycle where both valids are high and one is granted, making the arbitration round-robin.
  - An accepted request registers `rf_RegWrite`=1 with its addr and data. With no grant, `rf_RegWrite`=0 and addr/data hold their last values.
  - A write to address 0 is accepted but drives `rf_RegWrite`=0.
- Scoreboard:
  - `sb_set` sets `busy[sb_set_addr]`; a set to address 0 is ignored.
  - An accepted B write clears `busy[b_addr]` at the edge its `rf_RegWrite` commits into the register file.
  - A writes never touch `busy`.
  - If a set and a clear hit the same address on the same edge, the set wins.
- `busy[0]` is always 0.

## Timing
- Reset values: state `INIT`, counter 1, `prio_a`=1, `busy`=0, `init_done`=0, `rf_RegWrite`=0, `rf_WriteAddr`=0, `rf_WriteData`=0.
- First `INIT` write is driven in the first cycle after `Reset_n` deasserts.
- `init_done` rises in the cycle after the address-31 write is driven. The first handshake is possible in that same cycle.
- Handshake at edge t:
  - `rf_*` outputs are valid during cycle t..t+1.
  - the register file commits at edge t+1; data is readable after edge t+1.
  - for B, `busy` clears at edge t+1.
- `sb_set` at edge t: `busy` bit is high from t.
- Throughput is one write per cycle. Under contention each requester gets every other cycle.
- Asserting `Reset_n` low mid-sweep or mid-operation immediately forces the reset values. Any in-flight registered write is dropped, and the sweep restarts at address 1.

## Structure
- Package `regfile_ctrl_pkg` holds:
  - the state enum `{INIT, RUN}`
  - `ADDR_W`, `DATA_W`, `NREGS` defaults
  - the first and last sweep addresses (1, 31)
- Sub-module `regfile_scoreboard` owns the `busy` vector. Inputs: set addr/enable, clear addr/enable (the delayed B commit), and the async reset.
- Arbitration, the sweep counter and output registers live in the top.

## Test plan
- Reset release → exactly 31 writes, addr 1..31 in order, data 0. `init_done` rises at cycle 32. Readies stay 0 throughout the sweep.
- In `RUN`, A only: `a_addr`=5, `a_data`=0xDEADBEEF → `rf_WriteAddr`=5 with that data for one cycle. Register file reads 0xDEADBEEF afterwards.
- A and B both valid for 4 cycles (A addr 3, B addr 4) → grants A,B,A,B. `prio_a` alternates each cycle.
- `sb_set` addr 7, then B write addr 7 data 0x12345678 → `busy[7]` goes 1, then falls at the same edge the register file commits 0x12345678. Same-edge `sb_set` 7 with that commit → `busy[7]` stays 1.
- A write to addr 0 and `sb_set` addr 0 → handshake completes, `rf_RegWrite` stays 0, `busy[0]` stays 0.
- `Reset_n` pulsed low at sweep address 12 and again mid-traffic → outputs return to reset values immediately and `busy` clears. The sweep restarts at address 1.
